// File: rtl/mem_io_ctrl.sv
// Memory/IO sequencer for the eLC-3 MAR/MDR path: fixed wait-state access to async SRAM
// or to the memory-mapped keyboard/display registers, with a one-cycle ready pulse.
module mem_io_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [15:0] IO_BASE     = 16'hFE00
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  output logic        R,
  output logic [15:0] MIO_Data,
  output logic [15:0] SRAM_ADDR,
  input  logic [15:0] SRAM_DQ_In,
  output logic [15:0] SRAM_DQ_Out,
  output logic        SRAM_DQ_OE,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  input  logic        KB_Valid,
  input  logic [7:0]  KB_Char,
  output logic        Disp_Valid,
  input  logic        Disp_Ready,
  output logic [7:0]  Disp_Char,
  output logic        KB_IRQ
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0]  LAST_CNT  = 4'(WAIT_CYCLES - 1);
  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        rw_q, rw_d;
  logic        io_q, io_d;

  logic        r_q, r_d;
  logic [15:0] mio_data_q, mio_data_d;
  logic [15:0] sram_addr_q, sram_addr_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        dq_oe_q, dq_oe_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;

  logic        kb_full_q, kb_full_d;
  logic        kb_ie_q, kb_ie_d;
  logic [7:0]  kbdr_q, kbdr_d;
  logic        disp_valid_q, disp_valid_d;
  logic [7:0]  disp_char_q, disp_char_d;
  logic        kb_irq_q, kb_irq_d;

  logic        access_last;
  logic        io_rd, io_wr, kb_clr, sram_go;
  logic [15:0] io_rdata;

  assign access_last = (state_q == ACCESS) && (cnt_q == LAST_CNT);
  assign io_rd       = access_last && io_q && !rw_q;
  assign io_wr       = access_last && io_q && rw_q;
  assign kb_clr      = io_rd && (addr_q == ADDR_KBDR);

  always_comb begin
    io_rdata = 16'h0000;
    case (addr_q)
      ADDR_KBSR: io_rdata = {kb_full_q, kb_ie_q, 14'b0};
      ADDR_KBDR: io_rdata = {8'b0, kbdr_q};
      ADDR_DSR:  io_rdata = {~disp_valid_q, 15'b0};
      ADDR_DDR:  io_rdata = {8'b0, disp_char_q};
      default:   io_rdata = 16'h0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    io_d    = io_q;
    r_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (MIO_EN) begin
          state_d = ACCESS;
          cnt_d   = 4'd0;
          addr_d  = MAR;
          wdata_d = MDR;
          rw_d    = R_W;
          io_d    = (MAR >= IO_BASE);
        end
      end
      ACCESS: begin
        if (access_last) begin
          state_d = DONE;
          r_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRAM pins are computed from the next state so the registered strobes are
  // asserted for exactly the clocks spent in ACCESS.
  always_comb begin
    sram_go     = (state_d == ACCESS) && !io_d;
    ce_n_d      = !sram_go;
    oe_n_d      = !(sram_go && !rw_d);
    we_n_d      = !(sram_go && rw_d);
    dq_oe_d     = sram_go && rw_d;
    sram_addr_d = sram_go ? addr_d : sram_addr_q;
    dq_out_d    = (sram_go && rw_d) ? wdata_d : dq_out_q;
    mio_data_d  = mio_data_q;
    if (access_last && !rw_q) begin
      mio_data_d = io_q ? io_rdata : SRAM_DQ_In;
    end
  end

  always_comb begin
    kb_full_d    = kb_full_q;
    kb_ie_d      = kb_ie_q;
    kbdr_d       = kbdr_q;
    disp_valid_d = disp_valid_q;
    disp_char_d  = disp_char_q;
    if (io_wr && (addr_q == ADDR_KBSR)) begin
      kb_ie_d = wdata_q[14];
    end
    if (kb_clr) begin
      kb_full_d = 1'b0;
    end
    // A char arriving on the same edge the KBDR read clears full is kept.
    if (KB_Valid && (!kb_full_q || kb_clr)) begin
      kbdr_d    = KB_Char;
      kb_full_d = 1'b1;
    end
    if (disp_valid_q && Disp_Ready) begin
      disp_valid_d = 1'b0;
    end
    if (io_wr && (addr_q == ADDR_DDR) && (!disp_valid_q || Disp_Ready)) begin
      disp_char_d  = wdata_q[7:0];
      disp_valid_d = 1'b1;
    end
    kb_irq_d = kb_full_d && kb_ie_d;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      rw_q         <= 1'b0;
      io_q         <= 1'b0;
      r_q          <= 1'b0;
      mio_data_q   <= 16'h0000;
      sram_addr_q  <= 16'h0000;
      dq_out_q     <= 16'h0000;
      dq_oe_q      <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      kb_full_q    <= 1'b0;
      kb_ie_q      <= 1'b0;
      kbdr_q       <= 8'h00;
      disp_valid_q <= 1'b0;
      disp_char_q  <= 8'h00;
      kb_irq_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rw_q         <= rw_d;
      io_q         <= io_d;
      r_q          <= r_d;
      mio_data_q   <= mio_data_d;
      sram_addr_q  <= sram_addr_d;
      dq_out_q     <= dq_out_d;
      dq_oe_q      <= dq_oe_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      kb_full_q    <= kb_full_d;
      kb_ie_q      <= kb_ie_d;
      kbdr_q       <= kbdr_d;
      disp_valid_q <= disp_valid_d;
      disp_char_q  <= disp_char_d;
      kb_irq_q     <= kb_irq_d;
    end
  end

  assign R           = r_q;
  assign MIO_Data    = mio_data_q;
  assign SRAM_ADDR   = sram_addr_q;
  assign SRAM_DQ_Out = dq_out_q;
  assign SRAM_DQ_OE  = dq_oe_q;
  assign SRAM_CE_N   = ce_n_q;
  assign SRAM_OE_N   = oe_n_q;
  assign SRAM_WE_N   = we_n_q;
  assign Disp_Valid  = disp_valid_q;
  assign Disp_Char   = disp_char_q;
  assign KB_IRQ      = kb_irq_q;

endmodule
